// File: rtl/bus_mailbox.sv
// bus_mailbox: register-mapped mailbox with a TX FIFO (bus -> stream) and an
// RX FIFO (stream -> bus). Single-cycle request, registered response one
// cycle later. Both FIFOs are first-word-fall-through.
// Optional feature macro: BUS_MAILBOX_IRQ_EN enables the CTRL register and the
// level interrupt; without it CTRL reads 0 and irq_o is tied low.
module bus_mailbox #(
  parameter int Depth     = 8,
  parameter int DataWidth = 32
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 device_req_i,
  input  logic [31:0]          device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  output logic                 device_err_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [DataWidth-1:0] tx_data_o,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  input  logic [DataWidth-1:0] rx_data_i,
  output logic                 irq_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  // FIFO storage (not reset) and occupancy state
  logic [DataWidth-1:0] r_tx_mem [Depth];
  logic [DataWidth-1:0] r_rx_mem [Depth];
  logic [AW-1:0]        r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]        r_tx_cnt, r_rx_cnt;

  // Registered bus response
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  logic [1:0]           w_sel;
  logic                 w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic                 w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [DataWidth-1:0] w_tx_head, w_rx_head;
  logic [31:0]          w_status32;
  logic [DataWidth-1:0] w_status, w_ctrl_rd;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_err;
  logic                 w_unused;

  // Only addr[3:2] selects a register; the remaining address bits are ignored.
  assign w_unused = ^{device_addr_i[31:4], device_addr_i[1:0]};
  assign w_sel    = device_addr_i[3:2];

  assign w_tx_full  = (r_tx_cnt == CW'(Depth));
  assign w_tx_empty = (r_tx_cnt == {CW{1'b0}});
  assign w_rx_full  = (r_rx_cnt == CW'(Depth));
  assign w_rx_empty = (r_rx_cnt == {CW{1'b0}});

  assign w_tx_head = r_tx_mem[r_tx_rptr];
  assign w_rx_head = r_rx_mem[r_rx_rptr];

  // A full TX FIFO rejects a push even if the stream pops in the same cycle.
  assign w_tx_push = device_req_i & device_we_i & (w_sel == 2'd0) &
                     (device_be_i == 4'hF) & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & tx_ready_i;
  // rx_ready depends on occupancy only, so a same-cycle bus pop of a full
  // RX FIFO does not let the stream push in.
  assign w_rx_push = rx_valid_i & ~w_rx_full;
  assign w_rx_pop  = device_req_i & ~device_we_i & (w_sel == 2'd1) & ~w_rx_empty;

  assign tx_valid_o = ~w_tx_empty;
  assign tx_data_o  = w_tx_head;
  assign rx_ready_o = ~w_rx_full;

  assign w_status32 = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt), 4'h0,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
  assign w_status   = DataWidth'(w_status32);

`ifdef BUS_MAILBOX_IRQ_EN
  logic r_rx_irq_en, r_tx_irq_en, r_irq;

  // CTRL register: enable bits move only when the low byte lane is enabled
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
    end else if (device_req_i && device_we_i && (w_sel == 2'd3) && device_be_i[0]) begin
      r_rx_irq_en <= device_wdata_i[0];
      r_tx_irq_en <= device_wdata_i[1];
    end
  end

  // Level interrupt, registered from the current FIFO state
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty);
    end
  end

  assign irq_o     = r_irq;
  assign w_ctrl_rd = {{(DataWidth-2){1'b0}}, r_tx_irq_en, r_rx_irq_en};
`else
  assign irq_o     = 1'b0;
  assign w_ctrl_rd = {DataWidth{1'b0}};
`endif

  // TX storage write
  always_ff @(posedge clk_sys_i) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr] <= device_wdata_i;
    end
  end

  // RX storage write
  always_ff @(posedge clk_sys_i) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr] <= rx_data_i;
    end
  end

  // TX pointers and occupancy; simultaneous push/pop leaves the count unchanged
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_tx_wptr <= {AW{1'b0}};
      r_tx_rptr <= {AW{1'b0}};
      r_tx_cnt  <= {CW{1'b0}};
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + AW'(1);
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + AW'(1);
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // RX pointers and occupancy; simultaneous push/pop leaves the count unchanged
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rx_wptr <= {AW{1'b0}};
      r_rx_rptr <= {AW{1'b0}};
      r_rx_cnt  <= {CW{1'b0}};
    end else begin
      if (w_rx_push) begin
        r_rx_wptr <= r_rx_wptr + AW'(1);
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + AW'(1);
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Response decode: read data and error for the request in this cycle
  always_comb begin
    w_rdata = {DataWidth{1'b0}};
    w_err   = 1'b0;
    if (device_req_i) begin
      case (w_sel)
        2'd0: begin
          if (device_we_i && ((device_be_i != 4'hF) || w_tx_full)) begin
            w_err = 1'b1;
          end else begin
            w_err = 1'b0;
          end
        end
        2'd1: begin
          if (device_we_i) begin
            w_rdata = {DataWidth{1'b0}};
          end else if (w_rx_empty) begin
            w_err = 1'b1;
          end else begin
            w_rdata = w_rx_head;
          end
        end
        2'd2: begin
          if (device_we_i) begin
            w_rdata = {DataWidth{1'b0}};
          end else begin
            w_rdata = w_status;
          end
        end
        2'd3: begin
          if (device_we_i) begin
            w_rdata = {DataWidth{1'b0}};
          end else begin
            w_rdata = w_ctrl_rd;
          end
        end
        default: begin
          w_rdata = {DataWidth{1'b0}};
          w_err   = 1'b0;
        end
      endcase
    end else begin
      w_rdata = {DataWidth{1'b0}};
      w_err   = 1'b0;
    end
  end

  // Response register: one strobe per accepted request, data zero when idle
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DataWidth{1'b0}};
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= device_req_i;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
    end
  end

  assign device_rvalid_o = r_rvalid;
  assign device_rdata_o  = r_rdata;
  assign device_err_o    = r_err;

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: directed steps, bus responses and
// stream data checked against scoreboard queues filled at stimulus time.
module tb_bus_mailbox;

  localparam int DEPTH = 8;
`ifdef BUS_MAILBOX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_ni = 1'b1;
  logic        device_req_i = 1'b0;
  logic [31:0] device_addr_i = 32'h0;
  logic        device_we_i = 1'b0;
  logic [3:0]  device_be_i = 4'h0;
  logic [31:0] device_wdata_i = 32'h0;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;
  logic        device_err_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [31:0] tx_data_o;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [31:0] rx_data_i = 32'h0;
  logic        irq_o;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_req;
  rsp_t        mon_r;

  bus_mailbox #(.Depth(DEPTH), .DataWidth(32)) dut (
    .clk_sys_i      (clk_sys_i),
    .rst_sys_ni     (rst_sys_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .device_err_o   (device_err_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .tx_data_o      (tx_data_o),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .rx_data_i      (rx_data_i),
    .irq_o          (irq_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  // One-cycle bus request; expected response goes to the scoreboard
  task automatic bus(input logic we, input logic [1:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    rsp_t r;
    device_req_i   = 1'b1;
    device_we_i    = we;
    device_addr_i  = {28'h0, a, 2'b00};
    device_be_i    = be;
    device_wdata_i = wd;
    r.d = er;
    r.e = ee;
    sb.push_back(r);
    tick();
    device_req_i = 1'b0;
  endtask

  // One cycle of RX activity: optional stream word and optional RXDATA read
  task automatic step(input logic rv, input logic [31:0] rd, input logic rdreq);
    logic        acc;
    logic [31:0] er;
    logic        ee;
    acc = rv && (rxq.size() < DEPTH);
    rx_valid_i = rv;
    rx_data_i  = rd;
    chk("rx_ready", {31'h0, rx_ready_o}, {31'h0, rxq.size() < DEPTH});
    if (rdreq) begin
      if (rxq.size() > 0) begin
        er = rxq.pop_front();
        ee = 1'b0;
      end else begin
        er = 32'h0;
        ee = 1'b1;
      end
      bus(1'b0, 2'd1, 4'hF, 32'h0, er, ee);
    end else begin
      tick();
    end
    if (acc) rxq.push_back(rd);
    rx_valid_i = 1'b0;
  endtask

  // Response monitor: rvalid exactly one cycle after each request taken in reset-free cycle
  always @(posedge clk_sys_i) begin
    mon_req = device_req_i & rst_sys_ni;
    #1;
    chk("rvalid", {31'h0, device_rvalid_o}, {31'h0, mon_req});
    if (device_rvalid_o) begin
      chk("rsp_expected", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        mon_r = sb.pop_front();
        chk("rdata", device_rdata_o, mon_r.d);
        chk("err", {31'h0, device_err_o}, {31'h0, mon_r.e});
      end
    end else begin
      chk("rdata_idle", device_rdata_o, 32'h0);
    end
  end

  initial begin
    // Reset: outputs forced immediately
    #2 rst_sys_ni = 1'b0;
    #1;
    chk("rst_rvalid", {31'h0, device_rvalid_o}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready_o}, 32'h1);
    tick();
    tick();
    rst_sys_ni = 1'b1;
    tick();

    // Status after reset, CTRL cleared, TXDATA read returns 0
    bus(1'b0, 2'd2, 4'hF, 32'h0, 32'h0000_000A, 1'b0);
    bus(1'b0, 2'd3, 4'hF, 32'h0, 32'h0, 1'b0);
    bus(1'b0, 2'd0, 4'hF, 32'h0, 32'h0, 1'b0);
    // Partial byte enables rejected, FIFO stays empty
    bus(1'b1, 2'd0, 4'h3, 32'h55, 32'h0, 1'b1);
    bus(1'b0, 2'd2, 4'hF, 32'h0, 32'h0000_000A, 1'b0);

    // TX fill to full, overflow rejected
    tx_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus(1'b1, 2'd0, 4'hF, 32'h11 + i, 32'h0, 1'b0);
      txq.push_back(32'h11 + i);
    end
    bus(1'b1, 2'd0, 4'hF, 32'h99, 32'h0, 1'b1);
    bus(1'b0, 2'd2, 4'hF, 32'h0, 32'h0000_0809, 1'b0);
    tick();

    // TX drain in order
    tx_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 1 && txq.size() != 0; i++) begin
      chk("tx_valid", {31'h0, tx_valid_o}, 32'h1);
      chk("tx_data", tx_data_o, txq.pop_front());
      tick();
    end
    chk("tx_drained", {31'h0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;

    // RX fill to full, ignored RXDATA write, drain with underflow
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + i, 1'b0);
    chk("rx_full_ready", {31'h0, rx_ready_o}, 32'h0);
    bus(1'b1, 2'd1, 4'hF, 32'h77, 32'h0, 1'b0);
    bus(1'b0, 2'd2, 4'hF, 32'h0, 32'h0008_0006, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1);

    // Full RX: pop with stream valid blocks the push, next cycle accepts it
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hB0 + i, 1'b0);
    step(1'b1, 32'hC0, 1'b1);
    step(1'b1, 32'hC0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    // Wrap-around with simultaneous push and pop
    for (int i = 0; i < 20; i++) step(1'b1, 32'hD0 + i, 1'b1);
    for (int i = 0; i < DEPTH + 1 && rxq.size() != 0; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Interrupt: rx enable
    bus(1'b1, 2'd3, 4'h1, 32'h1, 32'h0, 1'b0);
    bus(1'b0, 2'd3, 4'hF, 32'h0, IRQ_ON ? 32'h1 : 32'h0, 1'b0);
    step(1'b1, 32'hE0, 1'b0);
    chk("irq_lat1", {31'h0, irq_o}, 32'h0);
    tick();
    chk("irq_rx_set", {31'h0, irq_o}, {31'h0, IRQ_ON});
    step(1'b0, 32'h0, 1'b1);
    chk("irq_rx_hold", {31'h0, irq_o}, {31'h0, IRQ_ON});
    tick();
    chk("irq_rx_clr", {31'h0, irq_o}, 32'h0);
    // Interrupt: tx-empty enable, then a write with be[0]=0 must not change CTRL
    bus(1'b1, 2'd3, 4'hF, 32'h2, 32'h0, 1'b0);
    chk("irq_tx_lat", {31'h0, irq_o}, 32'h0);
    tick();
    chk("irq_tx_set", {31'h0, irq_o}, {31'h0, IRQ_ON});
    bus(1'b1, 2'd3, 4'hE, 32'h0, 32'h0, 1'b0);
    bus(1'b0, 2'd3, 4'hF, 32'h0, IRQ_ON ? 32'h2 : 32'h0, 1'b0);

    // Reset during a TXDATA request with TX occupied
    bus(1'b1, 2'd0, 4'hF, 32'h33, 32'h0, 1'b0);
    tick();
    txq.delete();
    device_req_i   = 1'b1;
    device_we_i    = 1'b1;
    device_addr_i  = 32'h0;
    device_be_i    = 4'hF;
    device_wdata_i = 32'h44;
    #2 rst_sys_ni = 1'b0;
    #1;
    chk("rst2_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("rst2_irq", {31'h0, irq_o}, 32'h0);
    tick();
    device_req_i = 1'b0;
    tick();
    rst_sys_ni = 1'b1;
    tick();
    chk("rst2_tx_empty", {31'h0, tx_valid_o}, 32'h0);
    bus(1'b0, 2'd2, 4'hF, 32'h0, 32'h0000_000A, 1'b0);
    bus(1'b0, 2'd3, 4'hF, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst2_irq_after", {31'h0, irq_o}, 32'h0);
    chk("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_mailbox.md
BUS_MAILBOX -- requirements
Module: bus_mailbox

Interface
REQ-001 Parameter: Depth, default 8, entries per FIFO; power of two, range 2..64.
REQ-002 Parameter: DataWidth, default 32, width of bus data and of stream data.
REQ-003 clk_sys_i  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_sys_ni  in  1  reset, asynchronous, active-low.
REQ-005 device_req_i  in  1  bus request; accepted in the same cycle, no grant signal.
REQ-006 device_addr_i  in  32  byte address; only bits [3:2] are decoded.
REQ-007 device_we_i  in  1  1 = write, 0 = read.
REQ-008 device_be_i  in  4  byte enables.
REQ-009 device_wdata_i  in  32  write data.
REQ-010 device_rvalid_o  out  1  response strobe, one cycle after each accepted request.
REQ-011 device_rdata_o  out  32  read data, valid while device_rvalid_o=1, 0 otherwise.
REQ-012 device_err_o  out  1  error flag, qualified by device_rvalid_o.
REQ-013 tx_valid_o / tx_ready_i / tx_data_o  out / in / 32  drain stream for the TX FIFO.
REQ-014 rx_valid_i / rx_ready_o / rx_data_i  in / out / 32  fill stream for the RX FIFO.
REQ-015 irq_o  out  1  level interrupt.

Function
REQ-016 Register map by addr[3:2]:
- 0 TXDATA: write-only; reads return 0.
- 1 RXDATA: read-only; writes are ignored with err=0.
- 2 STATUS: read-only.
- 3 CTRL: read/write.
REQ-017 Every request produces exactly one response: device_rvalid_o=1 in cycle N+1 for a request in cycle N. Back-to-back requests produce back-to-back responses.
REQ-018 TXDATA write with be=4'hF and TX not full pushes wdata; err=0.
REQ-019 TXDATA write to a full TX FIFO, or with be!=4'hF, is discarded with err=1.
REQ-020 RXDATA read with RX not empty returns the head entry, pops it, and sets err=0.
REQ-021 RXDATA read with RX empty returns 0 with err=1; no state change.
REQ-022 STATUS bit layout:
- [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
- [15:8] tx_count, [23:16] rx_count.
- all other bits 0.
REQ-023 CTRL bit layout:
- [0] rx_irq_en, [1] tx_irq_en, other bits read 0.
- a write updates bits [1:0] only when be[0]=1.
REQ-024 tx_valid_o = !tx_empty; tx_data_o = TX head. A pop occurs on tx_valid_o & tx_ready_i.
REQ-025 rx_ready_o = !rx_full, combinational from occupancy only (a same-cycle bus pop does not raise it). A push occurs on rx_valid_i & rx_ready_o.
REQ-026 Simultaneous push and pop on one FIFO:
- count is unchanged and both pointers advance.
- pop-side data is the pre-push head.
- on an empty FIFO the pop cannot occur, by REQ-024 and REQ-021.
REQ-027 Pointers are log2(Depth) bits and wrap modulo Depth. Count is log2(Depth)+1 bits; full = (count==Depth).
REQ-028 The FIFOs are first-word-fall-through: data written in cycle N is visible at the head in cycle N+1.
REQ-029 irq_o = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), registered, with one cycle of latency from the state change.

Reset
REQ-030 On reset assertion, all outputs go to 0 immediately: rvalid, rdata, err, tx_valid, irq_o. rx_ready_o goes to 1.
REQ-031 Reset clears both FIFO pointers and counts and clears CTRL. FIFO storage is not reset.
REQ-032 Reset asserted mid-transaction drops the pending response; no rvalid is issued after deassertion for a pre-reset request.

Configuration
REQ-033 Macro BUS_MAILBOX_IRQ_EN defined: CTRL and irq_o behave per REQ-023 and REQ-029.
REQ-034 Macro BUS_MAILBOX_IRQ_EN undefined:
- no CTRL storage; CTRL reads return 0 and writes are accepted with err=0 and no effect.
- irq_o is tied to 0.
- all other behaviour is identical.

Verification
REQ-035 Reset, then read STATUS -> rdata=32'h0000_000A (tx_empty, rx_empty), err=0, rvalid exactly one cycle after req.
REQ-036 With tx_ready_i=0, write 0x11..0x18 to TXDATA (be=F), then a 9th write of 0x99 -> STATUS tx_full=1, tx_count=8, and the 9th response has err=1. Then raise tx_ready_i -> tx_data_o sequence 0x11..0x18 with 0x99 absent, then tx_valid_o=0.
REQ-037 Stream 0xA0..0xA7 on rx -> rx_ready_o=0 after the 8th word. Read RXDATA 9 times -> 0xA0..0xA7 with err=0, the 9th read returns 0 with err=1.
REQ-038 RX full, bus pop of RXDATA in the same cycle as rx_valid_i=1 -> no push that cycle, rx_count=7 next cycle, push accepted the following cycle; 20 wrap-around cycles with data order preserved.
REQ-039 With BUS_MAILBOX_IRQ_EN: write CTRL=1, then push one rx word -> irq_o=1 two cycles after the push; read RXDATA -> irq_o=0. Without the macro: the same stimulus keeps irq_o=0 and CTRL reads 0.
REQ-040 Assert reset during a TXDATA request cycle -> no rvalid after reset release, tx_empty=1, CTRL=0.
